// File: rtl/basic_sync_fifo_pkg.sv
// basic_sync_fifo_pkg: shared constants, the per-cycle operation type and a
// depth helper for the basic_sync_fifo circular buffer.
// The optional checks are enabled with the macro BASIC_FIFO_ASSERT_EN
// (consumed by basic_sync_fifo.sv).
package basic_sync_fifo_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Headroom left below full when almost_full fires, so the fetch pipeline
  // can drain its in-flight instructions into the queue after it stalls.
  localparam int ALMOST_FULL_MARGIN = 4;

  // What actually happens to the queue on a given edge, after qualification
  // against full/empty.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Number of entries addressed by a pointer of the given width.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/basic_sync_fifo_mem.sv
// basic_sync_fifo_mem: simple dual-port storage for the FIFO.
// Synchronous write, asynchronous read so the head entry is visible
// (show-ahead) without an extra pipeline stage. Contents are never reset.
module basic_sync_fifo_mem #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the incoming word at the write address when enabled.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/basic_sync_fifo.sv
// basic_sync_fifo: single-clock circular-buffer FIFO with first-word-fall-
// through read data, full/empty/almost flags and a synchronous clear.
// Sits between decode and issue; almost_full back-pressures fetch early
// enough to absorb the instructions still in flight.
// Optional macro BASIC_FIFO_ASSERT_EN compiles simulation-only checks for
// overflow, underflow and occupancy range; the logic is the same either way.
module basic_sync_fifo
  import basic_sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH             = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH             = DEFAULT_DATA_WIDTH,
  parameter int ALMOST_FULL_THRESHOLD  = fifo_depth(ADDR_WIDTH) - ALMOST_FULL_MARGIN,
  parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  // Thresholds and limits expressed at the width of the occupancy counter.
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LEVEL  = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESHOLD);
  localparam logic [ADDR_WIDTH:0] AE_LEVEL  = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_THRESHOLD);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;

  logic     do_push;
  logic     do_pop;
  logic     mem_wr_en;
  fifo_op_e op;

  // A pop needs data present; a push needs room, or a slot being vacated by
  // a same-cycle pop. When empty the pop is void, so a push-and-pop on an
  // empty queue degenerates into a plain push.
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);

  // Clear wins over push, so nothing lands in storage during a flush.
  assign mem_wr_en = do_push && !clear;

  // Classify this cycle's qualified operation for the pointer/count update.
  always_comb begin
    op = OP_IDLE;
    unique case ({do_pop, do_push})
      2'b01:   op = OP_PUSH;
      2'b10:   op = OP_POP;
      2'b11:   op = OP_BOTH;
      default: op = OP_IDLE;
    endcase
  end

  // Advance pointers and occupancy; clear flushes everything but storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
          count_reg  <= count_reg + CNT_ONE;
        end
        OP_POP: begin
          rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
          count_reg  <= count_reg - CNT_ONE;
        end
        OP_BOTH: begin
          // Occupancy is unchanged; at full the write reuses the slot the
          // pop is vacating because the pointers coincide.
          wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
          rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
        default: begin
          wr_ptr_reg <= wr_ptr_reg;
          rd_ptr_reg <= rd_ptr_reg;
          count_reg  <= count_reg;
        end
      endcase
    end
  end

  basic_sync_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // Flags come straight from the registered count, so they trail the causing
  // operation by exactly one edge.
  assign empty        = (count_reg == '0);
  assign full         = (count_reg == DEPTH_CNT);
  assign almost_empty = (count_reg <= AE_LEVEL);
  assign almost_full  = (count_reg >= AF_LEVEL);

`ifdef BASIC_FIFO_ASSERT_EN
  // Flag misuse by the surrounding pipeline while the queue is live.
  always @(posedge clk) begin
    if (rst && !clear) begin
      assert (!(push && full && !pop))
        else $error("basic_sync_fifo: push while full (overflow)");
      assert (!(pop && empty))
        else $error("basic_sync_fifo: pop while empty (underflow)");
      assert (count_reg <= DEPTH_CNT)
        else $error("basic_sync_fifo: occupancy %0d exceeds depth", count_reg);
    end
  end
`else
  // Overflow and underflow are silently absorbed by the qualification above.
`endif

endmodule

// File: tb/tb_basic_sync_fifo.sv
// tb_basic_sync_fifo: table-driven directed vectors, hand-written corner
// sequences and randomized traffic compared against a queue-based model of
// the FIFO for basic_sync_fifo (DEPTH 8, almost_full at 4, almost_empty at 1).
module tb_basic_sync_fifo;

  localparam int AW  = 3;
  localparam int DW  = 16;
  localparam int DEP = 8;
  localparam int AFT = 4;
  localparam int AET = 1;

  logic          clk;
  logic          rst;
  logic          clear;
  logic          push;
  logic          pop;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic          almost_empty;
  logic          almost_full;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the queue contents, head at index 0.
  logic [DW-1:0] mq[$];

  basic_sync_fifo #(
    .ADDR_WIDTH             (AW),
    .DATA_WIDTH             (DW),
    .ALMOST_FULL_THRESHOLD  (AFT),
    .ALMOST_EMPTY_THRESHOLD (AET)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .push         (push),
    .pop          (pop),
    .wr_data      (wr_data),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          c;
    logic          p;
    logic          q;
    logic [DW-1:0] d;
    logic          e;
    logic          f;
    logic          ae;
    logic          af;
    logic          rv;
    logic [DW-1:0] rd;
  } vec_t;

  vec_t vecs[35];

  function automatic vec_t mk(input logic c, input logic p, input logic q,
                              input logic [DW-1:0] d,
                              input logic e, input logic f, input logic ae,
                              input logic af, input logic rv,
                              input logic [DW-1:0] rd);
    vec_t v;
    v.c = c; v.p = p; v.q = q; v.d = d;
    v.e = e; v.f = f; v.ae = ae; v.af = af; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    else
      n_pass++;
  endtask

  // Drive one cycle of inputs, let the edge happen, update the model from
  // the rules (clear flushes; pop needs data; push needs room or a real pop).
  task automatic cycle(input logic c, input logic p, input logic q, input logic [DW-1:0] d);
    bit dpop;
    bit dpush;
    @(negedge clk);
    clear = c; push = p; pop = q; wr_data = d;
    @(posedge clk);
    if (c) begin
      mq.delete();
    end else begin
      dpop  = q && (mq.size() > 0);
      dpush = p && ((mq.size() < DEP) || dpop);
      if (dpop)  void'(mq.pop_front());
      if (dpush) mq.push_back(d);
    end
    #1;
    $display("cyc c=%0b push=%0b pop=%0b din=%h -> rd=%h e=%0b f=%0b ae=%0b af=%0b occ=%0d",
             c, p, q, d, rd_data, empty, full, almost_empty, almost_full, mq.size());
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".empty"},        32'(empty),        32'(mq.size() == 0));
    chk({tag, ".full"},         32'(full),         32'(mq.size() == DEP));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(mq.size() <= AET));
    chk({tag, ".almost_full"},  32'(almost_full),  32'(mq.size() >= AFT));
    if (mq.size() > 0)
      chk({tag, ".rd_data"}, 32'(rd_data), 32'(mq[0]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // show-ahead ordering
    vecs[0]  = mk(0,1,0,16'h00A1, 0,0,1,0, 1,16'h00A1);
    vecs[1]  = mk(0,1,0,16'h00A2, 0,0,0,0, 1,16'h00A1);
    vecs[2]  = mk(0,1,0,16'h00A3, 0,0,0,0, 1,16'h00A1);
    vecs[3]  = mk(0,0,1,16'h0000, 0,0,0,0, 1,16'h00A2);
    vecs[4]  = mk(0,0,1,16'h0000, 0,0,1,0, 1,16'h00A3);
    vecs[5]  = mk(0,0,1,16'h0000, 1,0,1,0, 0,16'h0000);
    // thresholds and full
    vecs[6]  = mk(0,1,0,16'h00B0, 0,0,1,0, 1,16'h00B0);
    vecs[7]  = mk(0,1,0,16'h00B1, 0,0,0,0, 1,16'h00B0);
    vecs[8]  = mk(0,1,0,16'h00B2, 0,0,0,0, 1,16'h00B0);
    vecs[9]  = mk(0,1,0,16'h00B3, 0,0,0,1, 1,16'h00B0);
    vecs[10] = mk(0,1,0,16'h00B4, 0,0,0,1, 1,16'h00B0);
    vecs[11] = mk(0,1,0,16'h00B5, 0,0,0,1, 1,16'h00B0);
    vecs[12] = mk(0,1,0,16'h00B6, 0,0,0,1, 1,16'h00B0);
    vecs[13] = mk(0,1,0,16'h00B7, 0,1,0,1, 1,16'h00B0);
    vecs[14] = mk(0,1,0,16'h00C9, 0,1,0,1, 1,16'h00B0);  // dropped
    // push+pop at full: 0xFF takes B0's slot and emerges 8th
    vecs[15] = mk(0,1,1,16'h00FF, 0,1,0,1, 1,16'h00B1);
    vecs[16] = mk(0,0,1,16'h0000, 0,0,0,1, 1,16'h00B2);
    vecs[17] = mk(0,0,1,16'h0000, 0,0,0,1, 1,16'h00B3);
    vecs[18] = mk(0,0,1,16'h0000, 0,0,0,1, 1,16'h00B4);
    vecs[19] = mk(0,0,1,16'h0000, 0,0,0,1, 1,16'h00B5);
    vecs[20] = mk(0,0,1,16'h0000, 0,0,0,0, 1,16'h00B6);
    vecs[21] = mk(0,0,1,16'h0000, 0,0,0,0, 1,16'h00B7);
    vecs[22] = mk(0,0,1,16'h0000, 0,0,1,0, 1,16'h00FF);
    vecs[23] = mk(0,0,1,16'h0000, 1,0,1,0, 0,16'h0000);
    vecs[24] = mk(0,0,1,16'h0000, 1,0,1,0, 0,16'h0000);  // underflow ignored
    // push+pop at empty behaves as a push
    vecs[25] = mk(0,1,1,16'h00D1, 0,0,1,0, 1,16'h00D1);
    vecs[26] = mk(0,0,1,16'h0000, 1,0,1,0, 0,16'h0000);
    // clear with push discards everything
    vecs[27] = mk(0,1,0,16'h00E0, 0,0,1,0, 1,16'h00E0);
    vecs[28] = mk(0,1,0,16'h00E1, 0,0,0,0, 1,16'h00E0);
    vecs[29] = mk(0,1,0,16'h00E2, 0,0,0,0, 1,16'h00E0);
    vecs[30] = mk(0,1,0,16'h00E3, 0,0,0,1, 1,16'h00E0);
    vecs[31] = mk(0,1,0,16'h00E4, 0,0,0,1, 1,16'h00E0);
    vecs[32] = mk(1,1,0,16'h00EE, 1,0,1,0, 0,16'h0000);
    vecs[33] = mk(0,1,0,16'h00F0, 0,0,1,0, 1,16'h00F0);
    vecs[34] = mk(0,0,1,16'h0000, 1,0,1,0, 0,16'h0000);

    // reset held for two edges
    rst = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset.empty",        32'(empty),        32'd1);
    chk("reset.almost_empty", 32'(almost_empty), 32'd1);
    chk("reset.full",         32'(full),         32'd0);
    chk("reset.almost_full",  32'(almost_full),  32'd0);
    mq.delete();

    // directed table
    for (int i = 0; i < 35; i++) begin
      cycle(vecs[i].c, vecs[i].p, vecs[i].q, vecs[i].d);
      chk($sformatf("vec%0d.empty", i),        32'(empty),        32'(vecs[i].e));
      chk($sformatf("vec%0d.full", i),         32'(full),         32'(vecs[i].f));
      chk($sformatf("vec%0d.almost_empty", i), 32'(almost_empty), 32'(vecs[i].ae));
      chk($sformatf("vec%0d.almost_full", i),  32'(almost_full),  32'(vecs[i].af));
      if (vecs[i].rv)
        chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].rd));
    end

    // wrap-around: occupancy held at 2, rolling data 0..19 plus 2 primers
    cycle(0, 1, 0, 16'd100);
    check_model("wrap.prime0");
    cycle(0, 1, 0, 16'd101);
    check_model("wrap.prime1");
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1, 16'(i));
      check_model($sformatf("wrap%0d", i));
      chk($sformatf("wrap%0d.occupancy2", i), 32'(almost_empty), 32'd0);
    end

    // asynchronous reset mid-stream: empty must rise before any clock edge
    @(negedge clk);
    push = 1'b1; pop = 1'b0; wr_data = 16'h1234;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst.empty", 32'(empty), 32'd1);
    chk("async_rst.full",  32'(full),  32'd0);
    push = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    mq.delete();
    #1;
    check_model("after_rst");

    // randomized traffic: fill-biased then drain-biased
    for (int i = 0; i < 400; i++) begin
      int pp = (i < 200) ? 70 : 35;
      int qp = (i < 200) ? 35 : 70;
      logic c = ($urandom_range(0, 99) < 3);
      logic p = ($urandom_range(0, 99) < pp);
      logic q = ($urandom_range(0, 99) < qp);
      cycle(c, p, q, 16'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
